serial_pattern_feeder: RTL and testbench

Upstream stimulus stage for the serial sequence detectors: accepts a WIDTH-bit parallel word through a valid/ready handshake and shifts it out one bit per clock on a single serial line. The serial line drives the detector's din. Supports gapless back-to-back words, so overlapping patterns that span word boundaries reach the detector intact. An optional idle gap can be inserted between words.

---
 rtl/serial_pattern_feeder.sv | 145 ++++++++++++++
 tb/tb_serial_pattern_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_feeder.sv
// Parallel-to-serial feeder with valid/ready load, gapless back-to-back words and optional idle gap.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit after each word.
`timescale 1ns/1ps
module serial_pattern_feeder #(
   parameter int WIDTH      = 4,
   parameter int GAP_CYCLES = 0,
   parameter int MSB_FIRST  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int NBITS = WIDTH + 1;
   localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
`else
   localparam int NBITS = WIDTH;
`endif
   localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [GW-1:0]    r_gap, w_gap_nxt;
   logic             r_sout, w_sout_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_last, w_last_nxt;
   logic             r_busy, w_busy_nxt;
   logic             w_last_bit, w_accept, w_first_bit, w_next_bit;
`ifdef SERIAL_FEEDER_PARITY_EN
   logic             r_parity, w_parity_nxt;
`endif

   assign w_last_bit  = (r_cnt == LAST_CNT);
   assign load_ready  = (r_state == S_IDLE) ||
                        ((r_state == S_SHIFT) && w_last_bit && (GAP_CYCLES == 0));
   assign w_accept    = load_valid && load_ready;
   // The bit to emit next always sits at the outgoing end of the shift register.
   assign w_shifted   = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
   assign w_first_bit = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
   assign w_next_bit  = (MSB_FIRST != 0) ? w_shifted[WIDTH-1] : w_shifted[0];

   always_comb begin
      w_state_nxt  = r_state;
      w_shift_nxt  = r_shift;
      w_cnt_nxt    = r_cnt;
      w_gap_nxt    = r_gap;
      w_sout_nxt   = 1'b0;
      w_valid_nxt  = 1'b0;
      w_last_nxt   = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      w_parity_nxt = r_parity;
`endif
      case (r_state)
         S_IDLE: ;
         S_SHIFT: begin
            if (!w_last_bit) begin
               w_cnt_nxt   = r_cnt + 1'b1;
               w_shift_nxt = w_shifted;
               w_valid_nxt = 1'b1;
               w_sout_nxt  = w_next_bit;
               w_last_nxt  = ((r_cnt + 1'b1) == LAST_CNT);
`ifdef SERIAL_FEEDER_PARITY_EN
               if (r_cnt == DATA_LAST) w_sout_nxt = r_parity;
`endif
            end else if (GAP_CYCLES > 0) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = '0;
               w_gap_nxt   = '0;
            end else begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         S_GAP: begin
            if (r_gap == GAP_LAST) begin
               w_state_nxt = S_IDLE;
               w_gap_nxt   = '0;
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // An accept (IDLE, or final bit when gapless) overrides the path chosen above.
      if (w_accept) begin
         w_state_nxt  = S_SHIFT;
         w_shift_nxt  = load_data;
         w_cnt_nxt    = '0;
         w_sout_nxt   = w_first_bit;
         w_valid_nxt  = 1'b1;
         w_last_nxt   = (NBITS == 1);
`ifdef SERIAL_FEEDER_PARITY_EN
         w_parity_nxt = ^load_data;
`endif
      end
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_gap    <= '0;
         r_sout   <= 1'b0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_busy   <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_shift  <= w_shift_nxt;
         r_cnt    <= w_cnt_nxt;
         r_gap    <= w_gap_nxt;
         r_sout   <= w_sout_nxt;
         r_valid  <= w_valid_nxt;
         r_last   <= w_last_nxt;
         r_busy   <= w_busy_nxt;
`ifdef SERIAL_FEEDER_PARITY_EN
         r_parity <= w_parity_nxt;
`endif
      end
   end

   assign sout       = r_sout;
   assign sout_valid = r_valid;
   assign sout_last  = r_last;
   assign busy       = r_busy;

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Bench for serial_pattern_feeder: three instances (gapless MSB-first, gap=2 LSB-first, WIDTH=1),
// scoreboard of expected serial bits plus hand-written cycle checks.
`timescale 1ns/1ps
module tb_serial_pattern_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB = 4 + PAR;

   typedef struct {
      logic b;
      logic last;
   } exp_t;

   typedef struct {
      int         idx;
      logic [3:0] data;
      logic [3:0] seq;   // bits in send order, seq[3] first
      logic       par;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       lv [0:2];
   logic [3:0] ld [0:2];
   logic       lr [0:2];
   logic       so [0:2];
   logic       sv [0:2];
   logic       sl [0:2];
   logic       bz [0:2];

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   vec_t tbl [10];

   serial_pattern_feeder #(.WIDTH(4), .GAP_CYCLES(0), .MSB_FIRST(1)) dut0 (
      .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld[0]),
      .sout(so[0]), .sout_valid(sv[0]), .sout_last(sl[0]), .busy(bz[0]));
   serial_pattern_feeder #(.WIDTH(4), .GAP_CYCLES(2), .MSB_FIRST(0)) dut1 (
      .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld[1]),
      .sout(so[1]), .sout_valid(sv[1]), .sout_last(sl[1]), .busy(bz[1]));
   serial_pattern_feeder #(.WIDTH(1), .GAP_CYCLES(0), .MSB_FIRST(1)) dut2 (
      .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(lr[2]), .load_data(ld[2][0:0]),
      .sout(so[2]), .sout_valid(sv[2]), .sout_last(sl[2]), .busy(bz[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      else n_pass++;
   endtask

   function automatic void push_exp(input int i, input exp_t e);
      case (i)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic int qsize(input int i);
      case (i)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t qpop(input int i);
      case (i)
         0: return q0.pop_front();
         1: return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   function automatic void push_word(input int i, input logic [3:0] seq, input logic par);
      int   w;
      exp_t e;
      w = (i == 2) ? 1 : 4;
      for (int k = 0; k < w; k++) begin
         e.b    = seq[w-1-k];
         e.last = (k == w - 1) && (PAR == 0);
         push_exp(i, e);
      end
      if (PAR != 0) begin
         e.b    = par;
         e.last = 1'b1;
         push_exp(i, e);
      end
   endfunction

   task automatic mon_one(input int i);
      exp_t e;
      if (sv[i]) begin
         chk($sformatf("bit_expected[%0d]", i), int'(qsize(i) > 0), 1);
         if (qsize(i) > 0) begin
            e = qpop(i);
            chk($sformatf("sout[%0d]", i), so[i], e.b);
            chk($sformatf("sout_last[%0d]", i), sl[i], e.last);
         end
      end else begin
         chk($sformatf("idle_zero[%0d]", i), {so[i], sl[i]}, 0);
      end
   endtask

   always @(negedge clk) begin
      if (reset) for (int i = 0; i < 3; i++) mon_one(i);
   end

   // Called just after a rising edge; returns just after the accept edge with load_valid dropped.
   task automatic send(input int i, input logic [3:0] data, input logic [3:0] seq, input logic par);
      bit done;
      done  = 0;
      lv[i] = 1'b1;
      ld[i] = data;
      for (int n = 0; n < 40 && !done; n++) begin
         if (lr[i]) begin
            push_word(i, seq, par);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      lv[i] = 1'b0;
      if (!done) chk("accept_timeout", 0, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{0, 4'b1101, 4'b1101, 1'b1};
      tbl[1] = '{0, 4'b1011, 4'b1011, 1'b1};
      tbl[2] = '{0, 4'b0000, 4'b0000, 1'b0};
      tbl[3] = '{0, 4'b1111, 4'b1111, 1'b0};
      tbl[4] = '{0, 4'b1001, 4'b1001, 1'b0};
      tbl[5] = '{0, 4'b0110, 4'b0110, 1'b0};
      tbl[6] = '{1, 4'b0011, 4'b1100, 1'b0};
      tbl[7] = '{1, 4'b1000, 4'b0001, 1'b1};
      tbl[8] = '{1, 4'b1110, 4'b0111, 1'b1};
      tbl[9] = '{1, 4'b0100, 4'b0010, 1'b1};

      // Reset with load_valid asserted: nothing may be accepted.
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lv[i] = 1'b1;
         ld[i] = 4'hF;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_sout", so[i], 0);
         chk("rst_valid", sv[i], 0);
         chk("rst_busy", bz[i], 0);
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) lv[i] = 1'b0;
      #1;
      chk("rst_ready", lr[0], 1);
      @(posedge clk);
      #1;
      chk("rst_no_accept", sv[0], 0);
      chk("rst_no_busy", bz[0], 0);

      // Single word, latency and sout_last placement.
      @(posedge clk);
      #1;
      send(0, 4'b1101, 4'b1101, 1'b1);
      for (int c = 1; c <= NB + 1; c++) begin
         @(negedge clk);
         chk("sw_valid", sv[0], int'(c <= NB));
         chk("sw_last", sl[0], int'(c == NB));
         chk("sw_busy", bz[0], int'(c <= NB));
      end

      // Gapless stream: 1101 then 1011 with no bubble, ready pulses on final bit.
      @(posedge clk);
      #1;
      lv[0] = 1'b1;
      ld[0] = 4'b1101;
      chk("gl_ready0", lr[0], 1);
      push_word(0, 4'b1101, 1'b1);
      @(posedge clk);
      #1;
      ld[0] = 4'b1011;
      for (int c = 1; c <= 2 * NB; c++) begin
         @(negedge clk);
         chk("gl_valid", sv[0], 1);
         chk("gl_ready", lr[0], int'((c == NB) || (c == 2 * NB)));
         if (c == NB) push_word(0, 4'b1011, 1'b1);
         if (c == NB + 1) lv[0] = 1'b0;
      end
      @(negedge clk);
      chk("gl_end_valid", sv[0], 0);

      // Gap of two cycles, LSB first.
      @(posedge clk);
      #1;
      lv[1] = 1'b1;
      ld[1] = 4'b0011;
      chk("gap_ready0", lr[1], 1);
      push_word(1, 4'b1100, 1'b0);
      @(posedge clk);
      #1;
      ld[1] = 4'b1000;
      for (int c = 1; c <= NB + 3; c++) begin
         @(negedge clk);
         if (c <= NB) begin
            chk("gap_shift_valid", sv[1], 1);
            chk("gap_shift_ready", lr[1], 0);
         end else if (c <= NB + 2) begin
            chk("gap_valid", sv[1], 0);
            chk("gap_ready", lr[1], 0);
            chk("gap_busy", bz[1], 1);
         end else begin
            chk("gap_idle_ready", lr[1], 1);
            chk("gap_idle_busy", bz[1], 0);
            push_word(1, 4'b0001, 1'b1);
         end
      end
      @(posedge clk);
      #1;
      lv[1] = 1'b0;
      repeat (NB + 4) @(posedge clk);
      #1;

      // Table of words across both 4-bit instances.
      for (int r = 0; r < 10; r++) send(tbl[r].idx, tbl[r].data, tbl[r].seq, tbl[r].par);
      repeat (3 * NB + 6) @(posedge clk);
      #1;

      // WIDTH=1 instance: one SHIFT cycle per word, back to back.
      send(2, 4'b0001, 4'b0001, 1'b1);
      send(2, 4'b0000, 4'b0000, 1'b0);
      send(2, 4'b0001, 4'b0001, 1'b1);
      repeat (6) @(posedge clk);
      #1;

      // Reset during bit 2 of 1111, then a clean 0101.
      send(0, 4'b1111, 4'b1111, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("mr_sout", so[0], 0);
      chk("mr_valid", sv[0], 0);
      chk("mr_last", sl[0], 0);
      chk("mr_busy", bz[0], 0);
      q0.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mr_no_resume", sv[0], 0);
      send(0, 4'b0101, 4'b0101, 1'b0);
      repeat (NB + 3) @(posedge clk);
      #1;

      for (int i = 0; i < 3; i++) chk($sformatf("queue_empty[%0d]", i), qsize(i), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
